// File: rtl/decoder_scan_if.sv
// Request/response bundle for decoder_scan. The master drives the request
// side (enable, mode, addresses); the slave returns the registered one-hot
// word, the current address and the scan status flags.
interface decoder_scan_if #(
  parameter int N = 5
);
  logic               en;
  logic               mode;
  logic               in_valid;
  logic               start;
  logic [N-1:0]       A;
  logic [N-1:0]       last;
  logic [(1<<N)-1:0]  Y;
  logic [N-1:0]       cur_addr;
  logic               busy;
  logic               done;

  modport master (
    output en, mode, in_valid, start, A, last,
    input  Y, cur_addr, busy, done
  );

  modport slave (
    input  en, mode, in_valid, start, A, last,
    output Y, cur_addr, busy, done
  );
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder with an address scanner.
// Direct mode decodes A into a one-hot word one cycle later. Scan mode walks
// a one-hot bit from A to last (inclusive, wrapping through 2^N-1 -> 0), one
// address per enabled cycle, then pulses done for one cycle.
// Build option: define DECODER_SCAN_EN to build the scanner (SCAN/DONE
// states and scan counter). Without it only direct decode exists; mode,
// start and last are ignored and busy/done are tied low.
module decoder_scan #(
  parameter int N = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_scan_if.slave bus
);

  localparam int W = 1 << N;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] a);
    logic [W-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  logic [W-1:0] y, y_n;
  logic [N-1:0] cur, cur_n;

`ifdef DECODER_SCAN_EN

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t       state, state_n;
  logic [N-1:0] last_q, last_n;

  // State, output word, current address and latched end address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      y      <= '0;
      cur    <= '0;
      last_q <= '0;
    end else begin
      state  <= state_n;
      y      <= y_n;
      cur    <= cur_n;
      last_q <= last_n;
    end
  end

  // Next-state and next-output decision; everything holds unless changed.
  always_comb begin
    state_n = state;
    y_n     = y;
    cur_n   = cur;
    last_n  = last_q;
    case (state)
      IDLE: begin
        if (!bus.en) begin
          y_n = '0;
        end else if (bus.mode) begin
          // start wins over in_valid; in_valid has no effect in scan mode
          if (bus.start) begin
            cur_n   = bus.A;
            last_n  = bus.last;
            y_n     = onehot(bus.A);
            state_n = SCAN;
          end
        end else if (bus.in_valid) begin
          cur_n = bus.A;
          y_n   = onehot(bus.A);
        end
      end
      SCAN: begin
        if (bus.en) begin
          if (cur == last_q) begin
            y_n     = '0;
            state_n = DONE;
          end else begin
            // N-bit add wraps 2^N-1 -> 0 for ranges with last < start
            cur_n = cur + N'(1);
            y_n   = onehot(cur_n);
          end
        end
      end
      DONE: begin
        y_n     = '0;
        state_n = IDLE;
      end
      default: begin
        y_n     = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy = (state == SCAN);
  assign bus.done = (state == DONE);

`else

  logic unused_scan_inputs;

  // Output word and current address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      cur <= '0;
    end else begin
      y   <= y_n;
      cur <= cur_n;
    end
  end

  // Direct decode only: accept on en & in_valid, clear on !en, else hold.
  always_comb begin
    y_n   = y;
    cur_n = cur;
    if (!bus.en) begin
      y_n = '0;
    end else if (bus.in_valid) begin
      cur_n = bus.A;
      y_n   = onehot(bus.A);
    end
  end

  assign unused_scan_inputs = ^{bus.mode, bus.start, bus.last};
  assign bus.busy = 1'b0;
  assign bus.done = 1'b0;

`endif

  assign bus.Y        = y;
  assign bus.cur_addr = cur;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan (N=5). A queue-based behavioural
// model predicts Y/cur_addr/busy/done and is compared every cycle; directed
// sequences also pin literal values. Honours DECODER_SCAN_EN like the design.
module tb_decoder_scan;

  localparam int N = 5;
  localparam int W = 1 << N;

  logic clk;
  logic rst_n;

  decoder_scan_if #(.N(N)) bus ();

  decoder_scan #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: q holds the addresses still to be shown in a scan,
  // front = address currently on Y. Empty queue means not scanning.
  logic [W-1:0] m_y    = '0;
  logic [N-1:0] m_cur  = '0;
  bit           m_done = 1'b0;
  int           q[$];

  task automatic model_reset();
    m_y    = '0;
    m_cur  = '0;
    m_done = 1'b0;
    q.delete();
  endtask

  // Advance the model by one rising edge using the inputs that edge samples.
  task automatic model_step();
    bit scan_mode;
    int count;
`ifdef DECODER_SCAN_EN
    scan_mode = bus.mode;
`else
    scan_mode = 1'b0;
`endif
    if (m_done) begin
      m_done = 1'b0;
    end else if (q.size() != 0) begin
      if (bus.en) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_y    = '0;
          m_done = 1'b1;
        end else begin
          m_cur = N'(q[0]);
          m_y   = W'(1) << q[0];
        end
      end
    end else if (!bus.en) begin
      m_y = '0;
    end else if (scan_mode) begin
      if (bus.start) begin
        count = (((int'(bus.last) - int'(bus.A)) % W + W) % W) + 1;
        for (int i = 0; i < count; i++) q.push_back((int'(bus.A) + i) % W);
        m_cur = bus.A;
        m_y   = W'(1) << bus.A;
      end
    end else if (bus.in_valid) begin
      m_cur = bus.A;
      m_y   = W'(1) << bus.A;
    end
  endtask

  // Inputs change only at posedge+1, so at negedge they are what the next
  // edge will sample: compare first, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("Y", bus.Y, m_y);
    chk("cur_addr", bus.cur_addr, m_cur);
    chk("busy", bus.busy, q.size() != 0);
    chk("done", bus.done, m_done);
    if (rst_n) model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt;
  logic [W-1:0] fwd_exp [4];

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.A        = '0;
    bus.last     = '0;
    step();
    step();
    chk("rst_Y", bus.Y, 0);
    chk("rst_cur", bus.cur_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst_n = 1'b1;

    // direct decode then disable
    bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1; bus.A = 5'b10100;
    step();
    chk("dir_Y", bus.Y, 32'h0010_0000);
    chk("dir_cur", bus.cur_addr, 20);
    chk("model_dir_Y", m_y, 32'h0010_0000);
    bus.en = 1'b0; bus.in_valid = 1'b0;
    step();
    chk("dis_Y", bus.Y, 0);
    chk("dis_cur", bus.cur_addr, 20);

    // direct hold
    bus.en = 1'b1; bus.in_valid = 1'b1; bus.A = 5'd16;
    step();
    bus.in_valid = 1'b0; bus.A = 5'd10;
    step();
    step();
    chk("hold_Y", bus.Y, 32'h0001_0000);
    chk("model_hold_Y", m_y, 32'h0001_0000);

`ifdef DECODER_SCAN_EN
    // forward scan 3..6
    fwd_exp[0] = 32'h0000_0008; fwd_exp[1] = 32'h0000_0010;
    fwd_exp[2] = 32'h0000_0020; fwd_exp[3] = 32'h0000_0040;
    bus.mode = 1'b1; bus.start = 1'b1; bus.A = 5'd3; bus.last = 5'd6;
    step();
    bus.start = 1'b0; bus.A = 5'd0; bus.last = 5'd0; bus.mode = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      chk("fwd_Y", bus.Y, fwd_exp[i]);
      if (bus.busy) busy_cnt++;
      step();
    end
    chk("fwd_end_Y", bus.Y, 0);
    chk("fwd_end_done", bus.done, 1);
    chk("fwd_end_busy", bus.busy, 0);
    step();
    chk("fwd_done_pulse", bus.done, 0);
    chk("fwd_busy_cnt", busy_cnt, 4);

    // wrap scan 30..1 with a two-cycle pause on 31
    bus.mode = 1'b1; bus.start = 1'b1; bus.A = 5'd30; bus.last = 5'd1;
    step();
    bus.start = 1'b0;
    chk("wrap_30", bus.Y, 32'h4000_0000);
    step();
    chk("wrap_31a", bus.Y, 32'h8000_0000);
    bus.en = 1'b0;
    step();
    chk("wrap_31b", bus.Y, 32'h8000_0000);
    chk("wrap_pause_busy", bus.busy, 1);
    step();
    chk("wrap_31c", bus.Y, 32'h8000_0000);
    bus.en = 1'b1;
    step();
    chk("wrap_0", bus.Y, 32'h0000_0001);
    chk("wrap_0_cur", bus.cur_addr, 0);
    step();
    chk("wrap_1", bus.Y, 32'h0000_0002);
    step();
    chk("wrap_done", bus.done, 1);
    chk("wrap_done_Y", bus.Y, 0);
    step();
    chk("wrap_idle_done", bus.done, 0);

    // start beats in_valid; single-address scan
    bus.mode = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.A = 5'd9; bus.last = 5'd9;
    step();
    bus.start = 1'b0; bus.in_valid = 1'b0;
    chk("prio_Y", bus.Y, 32'h0000_0200);
    chk("prio_busy", bus.busy, 1);
    step();
    chk("prio_done", bus.done, 1);
    step();

    // reset mid-scan aborts without done
    bus.mode = 1'b1; bus.start = 1'b1; bus.A = 5'd2; bus.last = 5'd20;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("abort_pre_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_Y", bus.Y, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", bus.done, 0);
    end
`else
    // scanner absent: the priority stimulus is a plain direct decode
    bus.mode = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.A = 5'd9; bus.last = 5'd9;
    step();
    bus.start = 1'b0; bus.in_valid = 1'b0;
    chk("nscan_Y", bus.Y, 32'h0000_0200);
    chk("nscan_cur", bus.cur_addr, 9);
    chk("nscan_busy", bus.busy, 0);
    chk("nscan_done", bus.done, 0);
    bus.start = 1'b1; bus.A = 5'd3; bus.last = 5'd6;
    step();
    bus.start = 1'b0;
    chk("nscan_start_ignored", bus.Y, 32'h0000_0200);
`endif

    // randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.mode     = $urandom_range(0, 1);
      bus.in_valid = $urandom_range(0, 1);
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.A        = N'($urandom);
      bus.last     = ($urandom_range(0, 3) == 0) ? bus.A : N'($urandom);
      step();
    end
    rst_n = 1'b1;
    bus.en = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
